mul_seq: RTL and testbench

//  Sequential shift-and-add multiply-accumulate, the inverse of the 6-bit combinational divider:

---
 rtl/mul_seq.sv | 121 ++++++++++++
 tb/tb_mul_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-and-add multiply-accumulate.
//   out = in1 * in2 + in3. This regenerates a dividend from a divider's
//   quotient, divisor and remainder. The block handles one multiplier bit per
//   clock, so it spends width RUN cycles and then one DONE cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request. It is sampled only in IDLE.
//   in1    multiplicand (quotient)
//   in2    multiplier (divisor)
//   in3    addend (remainder), zero-extended
//   busy   high in RUN and DONE
//   done   one-cycle pulse that marks out/ovf as valid
//   out    2*width-bit result
//   ovf    set when the result does not fit in width bits
module mul_seq #(
    parameter int width = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [width-1:0]   in1,
    input  logic [width-1:0]   in2,
    input  logic [width-1:0]   in3,
    output logic               busy,
    output logic               done,
    output logic [2*width-1:0] out,
    output logic               ovf
);

    localparam int CNT_W = $clog2(width + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(width - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*width-1:0]   acc_q, acc_d;
    logic [2*width-1:0]   mcand_q, mcand_d;
    logic [width-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*width-1:0]   out_q, out_d;
    logic                 ovf_q, ovf_d;
    logic [2*width-1:0]   acc_sum;

    // The largest value, (2^w-1)^2 + (2^w-1), is below 2^(2w), so this
    // sum never wraps.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = {{width{1'b0}}, in3};
                    mcand_d  = {{width{1'b0}}, in1};
                    mplier_d = in2;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // The last multiplier bit is being consumed, so publish the
                // result straight from the adder.
                if (cnt_q == CNT_LAST) begin
                    out_d   = acc_sum;
                    ovf_d   = |acc_sum[2*width-1:width];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
        end
    end

    // busy and done are Moore outputs. They are decoded from the registered
    // state only.
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign out  = out_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

    localparam int W = 6;

    logic             clk;
    logic             rst;
    logic             start;
    logic [W-1:0]     in1, in2, in3;
    logic             busy, done, ovf;
    logic [2*W-1:0]   out;

    int total;
    int fails;

    mul_seq #(.width(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .in3   (in3),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Run one operation and check busy every cycle, the latency (done must
    // appear in the 7th busy cycle), the result, and the return to idle.
    // When repulse is set, start is pulsed again during RUN with different
    // operands. That request must be ignored.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [2*W-1:0] exp_out,
                         input logic exp_ovf, input bit repulse);
        int n;
        bit seen;
        @(negedge clk);
        in1 = a; in2 = b; in3 = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        seen = 0;
        while (n <= 20 && !seen) begin
            if (done) begin
                seen = 1;
            end else begin
                if (!busy) begin
                    chk({tag, "_busy"}, busy, 1);
                end
                if (repulse && n == 2) begin
                    start = 1'b1; in1 = 6'd1; in2 = 6'd1; in3 = 6'd1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, seen ? n : 99, 7);
        chk({tag, "_busy_at_done"}, busy, 1);
        chk({tag, "_out"}, out, exp_out);
        chk({tag, "_ovf"}, ovf, exp_ovf);
        @(negedge clk);
        chk({tag, "_done_fall"}, done, 0);
        chk({tag, "_busy_fall"}, busy, 0);
        chk({tag, "_out_hold"}, out, exp_out);
    endtask

    initial begin
        int n;
        int t_first, t_second;
        logic [2*W-1:0] out_first, out_second;
        logic ovf_first, ovf_second;
        bit done_seen;

        total = 0;
        fails = 0;
        rst = 1'b1;
        start = 1'b0;
        in1 = '0; in2 = '0; in3 = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out", out, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        do_op("t1", 6'd7, 6'd8, 6'd7, 12'd63, 1'b0, 0);
        do_op("t2", 6'd7, 6'd9, 6'd5, 12'd68, 1'b1, 0);
        do_op("t3", 6'd63, 6'd63, 6'd63, 12'd4032, 1'b1, 0);
        do_op("t4a", 6'd0, 6'd45, 6'd12, 12'd12, 1'b0, 0);
        do_op("t4b", 6'd45, 6'd0, 6'd12, 12'd12, 1'b0, 0);
        do_op("t5", 6'd10, 6'd10, 6'd3, 12'd103, 1'b1, 1);

        // Assert reset in the 3rd RUN cycle. The old result must hold until
        // then, and reset must clear everything at once.
        @(negedge clk);
        in1 = 6'd20; in2 = 6'd20; in3 = 6'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_busy_run", busy, 1);
        chk("t6_out_held", out, 103);
        rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_out", out, 0);
        chk("t6_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_seen = 1;
        end
        chk("t6_no_done", done_seen, 0);
        do_op("t6_after", 6'd5, 6'd5, 6'd2, 12'd27, 1'b0, 0);

        // Hold start high across two operand sets. Expect done pulses 8
        // cycles apart.
        @(negedge clk);
        in1 = 6'd20; in2 = 6'd3; in3 = 6'd1; start = 1'b1;
        @(negedge clk);
        in1 = 6'd33; in2 = 6'd2; in3 = 6'd0;
        t_first = -1; t_second = -1;
        out_first = '0; out_second = '0; ovf_first = 0; ovf_second = 0;
        n = 1;
        while (n <= 40 && t_second < 0) begin
            if (done) begin
                if (t_first < 0) begin
                    t_first = n; out_first = out; ovf_first = ovf;
                end else begin
                    t_second = n; out_second = out; ovf_second = ovf;
                    start = 1'b0;
                end
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("t7_first_lat", t_first, 7);
        chk("t7_gap", (t_first >= 0 && t_second >= 0) ? (t_second - t_first) : 99, 8);
        chk("t7_out1", out_first, 61);
        chk("t7_ovf1", ovf_first, 0);
        chk("t7_out2", out_second, 66);
        chk("t7_ovf2", ovf_second, 1);
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("t7_idle", busy, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
